// File: rtl/sysarr_pkg.sv
// sysarr_pkg: shared types, default widths and index-width helper for the systolic-array result path.
package sysarr_pkg;

    localparam int DIN_WIDTH  = 8;
    localparam int DOUT_WIDTH = 16;

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sysarr_result_bank.sv
// sysarr_result_bank: one ping-pong bank -- element storage, row valid mask and fill state.
module sysarr_result_bank
    import sysarr_pkg::*;
#(
    parameter int DOUT_WIDTH = sysarr_pkg::DOUT_WIDTH,
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [DOUT_WIDTH-1:0] wr_data,
    input  logic                  rel,
    output logic [N-1:0]          mask,
    output logic                  full,
    output logic                  empty,
    output logic [DOUT_WIDTH-1:0] data [N]
);

    bank_state_e           state_q, state_d;
    logic [N-1:0]          mask_q, mask_d;
    logic [DOUT_WIDTH-1:0] data_q [N];
    logic [DOUT_WIDTH-1:0] data_d [N];

    // Release clears the mask first so a same-cycle write starts a fresh frame.
    always_comb begin
        mask_d  = (rel ? '0 : mask_q) | (wr_en ? (N'(1) << wr_idx) : '0);
        state_d = &mask_d ? BANK_FULL : (|mask_d ? BANK_FILLING : BANK_EMPTY);
        data_d  = data_q;
        if (wr_en) data_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_EMPTY;
            mask_q  <= '0;
            data_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    assign mask  = mask_q;
    assign full  = (state_q == BANK_FULL);
    assign empty = (state_q == BANK_EMPTY);
    assign data  = data_q;

endmodule

// File: rtl/sysarr_result_collector.sv
// sysarr_result_collector: reassembles serialized array results into parallel vectors via two ping-pong banks.
// Optional SYSARR_COLLECT_ERR_CHECK_EN adds seq_err and rejects duplicate indices.
module sysarr_result_collector
    import sysarr_pkg::*;
#(
    parameter int DOUT_WIDTH = sysarr_pkg::DOUT_WIDTH,
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DOUT_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic [IW-1:0]         s_idx,
    output logic [DOUT_WIDTH-1:0] m_data [N],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ovf,
    output logic                  busy
`ifdef SYSARR_COLLECT_ERR_CHECK_EN
    ,
    output logic                  seq_err
`endif
);

    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, ovf_q, ovf_d;
    logic [1:0]            full, empty, rel, wr_en;
    logic [N-1:0]          mask [2];
    logic [DOUT_WIDTH-1:0] bank_data [2][N];
    logic [N-1:0]          new_mask;
    logic                  hs, tgt_free, in_range, accept;
`ifdef SYSARR_COLLECT_ERR_CHECK_EN
    logic                  dup, first, seq_err_q, seq_err_d;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sysarr_result_bank #(.DOUT_WIDTH(DOUT_WIDTH), .N(N)) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (wr_en[b]),
            .wr_idx (s_idx),
            .wr_data(s_data),
            .rel    (rel[b]),
            .mask   (mask[b]),
            .full   (full[b]),
            .empty  (empty[b]),
            .data   (bank_data[b])
        );
    end

    always_comb begin
        m_valid  = full[rd_bank_q];
        hs       = m_valid && m_ready;
        rel      = hs ? (rd_bank_q ? 2'b10 : 2'b01) : 2'b00;
        in_range = int'(s_idx) < N;
        // A FULL write bank is still usable when it is being released this same cycle.
        tgt_free = !full[wr_bank_q] || rel[wr_bank_q];
`ifdef SYSARR_COLLECT_ERR_CHECK_EN
        dup       = in_range && mask[wr_bank_q][s_idx] && !rel[wr_bank_q];
        first     = rel[wr_bank_q] || (mask[wr_bank_q] == '0);
        accept    = s_valid && tgt_free && in_range && !dup;
        seq_err_d = s_valid && tgt_free && (!in_range || dup || (first && s_idx != '0));
`else
        accept    = s_valid && tgt_free && in_range;
`endif
        wr_en     = {accept && wr_bank_q, accept && !wr_bank_q};
        new_mask  = (rel[wr_bank_q] ? '0 : mask[wr_bank_q]) | (N'(1) << s_idx);
        wr_bank_d = (accept && &new_mask) ? !wr_bank_q : wr_bank_q;
        rd_bank_d = hs ? !rd_bank_q : rd_bank_q;
        ovf_d     = s_valid && !tgt_free;
        busy      = !(&empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SYSARR_COLLECT_ERR_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seq_err_q <= 1'b0;
        else        seq_err_q <= seq_err_d;
    end

    assign seq_err = seq_err_q;
`endif

    assign ovf    = ovf_q;
    assign m_data = bank_data[rd_bank_q];

endmodule

// File: tb/tb_sysarr_result_collector.sv
// tb_sysarr_result_collector: directed plus random stimulus against a frame-queue model of the collector.
module tb_sysarr_result_collector;

    localparam int N  = 4;
    localparam int DW = 16;
`ifdef SYSARR_COLLECT_ERR_CHECK_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef logic [N-1:0][DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic [1:0]    s_idx = '0;
    logic [DW-1:0] m_data [N];
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          ovf;
    logic          busy;
    logic          seq_err;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int err_cnt = 0;

    frame_t     fq[$];
    frame_t     pdata;
    logic [N-1:0] pmask;
    logic       e_ovf, e_err;

    sysarr_result_collector #(.DOUT_WIDTH(DW), .N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_idx  (s_idx),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .ovf    (ovf),
        .busy   (busy)
`ifdef SYSARR_COLLECT_ERR_CHECK_EN
        ,
        .seq_err(seq_err)
`endif
    );
`ifndef SYSARR_COLLECT_ERR_CHECK_EN
    assign seq_err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: completed frames wait in arrival order; at most two frames (filling or full) exist.
    task automatic model_update();
        int  sz;
        logic hs;
        sz = fq.size();
        hs = (sz > 0) && m_ready;
        if (hs) void'(fq.pop_front());
        e_ovf = 1'b0;
        e_err = 1'b0;
        if (s_valid) begin
            if (sz == 2 && !hs) e_ovf = 1'b1;
            else begin
                if (ERR && pmask == '0 && s_idx != 2'd0) e_err = 1'b1;
                if (ERR && pmask[s_idx]) e_err = 1'b1;
                else begin
                    pdata[s_idx] = s_data;
                    pmask[s_idx] = 1'b1;
                end
                if (&pmask) begin
                    fq.push_back(pdata);
                    pmask = '0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("m_valid", 32'(m_valid), 32'(fq.size() > 0));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("busy", 32'(busy), 32'(fq.size() > 0 || pmask != '0));
        if (ERR) chk("seq_err", 32'(seq_err), 32'(e_err));
        if (fq.size() > 0)
            for (int i = 0; i < N; i++) chk("m_data", 32'(m_data[i]), 32'(fq[0][i]));
    endtask

    task automatic step(input logic v, input logic [1:0] idx, input logic [DW-1:0] d, input logic r);
        s_valid = v;
        s_idx   = idx;
        s_data  = d;
        m_ready = r;
        @(posedge clk);
        model_update();
        #1;
        compare();
        ovf_cnt += int'(ovf);
        err_cnt += int'(seq_err);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        fq.delete();
        pmask = '0;
        e_ovf = 1'b0;
        e_err = 1'b0;
        #12;
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < N; i++) chk("rst m_data", 32'(m_data[i]), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input logic r);
        for (int i = 0; i < N; i++) step(1'b1, 2'(i), base + DW'(i), r);
    endtask

    initial begin
        pmask = '0;
        do_reset();

        // Back-to-back in-order frame, always ready.
        step(1'b1, 2'd0, 16'h0010, 1'b1);
        step(1'b1, 2'd1, 16'h0020, 1'b1);
        step(1'b1, 2'd2, 16'h0030, 1'b1);
        chk("t1 not yet valid", 32'(m_valid), 32'd0);
        step(1'b1, 2'd3, 16'h0040, 1'b1);
        chk("t1 valid", 32'(m_valid), 32'd1);
        chk("t1 d0", 32'(m_data[0]), 32'h10);
        chk("t1 d1", 32'(m_data[1]), 32'h20);
        chk("t1 d2", 32'(m_data[2]), 32'h30);
        chk("t1 d3", 32'(m_data[3]), 32'h40);
        step(1'b0, 2'd0, 16'h0, 1'b1);
        chk("t1 one cycle", 32'(m_valid), 32'd0);

        // Out-of-order indices.
        step(1'b1, 2'd2, 16'h00c2, 1'b0);
        step(1'b1, 2'd0, 16'h00c0, 1'b0);
        step(1'b1, 2'd3, 16'h00c3, 1'b0);
        chk("t2 3 beats", 32'(m_valid), 32'd0);
        step(1'b1, 2'd1, 16'h00c1, 1'b0);
        chk("t2 valid", 32'(m_valid), 32'd1);
        for (int i = 0; i < N; i++) chk("t2 row", 32'(m_data[i]), 32'h00c0 + i);
        step(1'b0, 2'd0, 16'h0, 1'b1);

        // Stall: two frames held, third dropped beat by beat.
        ovf_cnt = 0;
        send_frame(16'h1000, 1'b0);
        send_frame(16'h2000, 1'b0);
        send_frame(16'h3000, 1'b0);
        chk("t3 ovf pulses", 32'(ovf_cnt), 32'd4);
        step(1'b0, 2'd0, 16'h0, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b0);
        chk("t3 stable", 32'(m_data[3]), 32'h1003);
        step(1'b0, 2'd0, 16'h0, 1'b1);
        chk("t3 second", 32'(m_data[3]), 32'h2003);
        step(1'b0, 2'd0, 16'h0, 1'b1);
        chk("t3 drained", 32'(m_valid), 32'd0);
        chk("t3 idle", 32'(busy), 32'd0);

        // Release and write into the same bank in one cycle.
        send_frame(16'h4000, 1'b0);
        send_frame(16'h5000, 1'b0);
        step(1'b1, 2'd0, 16'h6000, 1'b1);
        chk("t4 no ovf", 32'(ovf), 32'd0);
        chk("t4 next", 32'(m_data[0]), 32'h5000);
        step(1'b1, 2'd1, 16'h6001, 1'b0);
        step(1'b1, 2'd2, 16'h6002, 1'b0);
        step(1'b1, 2'd3, 16'h6003, 1'b0);
        step(1'b0, 2'd0, 16'h0, 1'b1);
        chk("t4 third", 32'(m_data[0]), 32'h6000);
        step(1'b0, 2'd0, 16'h0, 1'b1);
        chk("t4 done", 32'(m_valid), 32'd0);

        // Reset mid-frame.
        step(1'b1, 2'd0, 16'h0bad, 1'b1);
        step(1'b1, 2'd1, 16'h0bad, 1'b1);
        do_reset();
        send_frame(16'h00a0, 1'b0);
        chk("t5 valid", 32'(m_valid), 32'd1);
        chk("t5 d0", 32'(m_data[0]), 32'h00a0);
        chk("t5 d1", 32'(m_data[1]), 32'h00a1);
        step(1'b0, 2'd0, 16'h0, 1'b1);

`ifdef SYSARR_COLLECT_ERR_CHECK_EN
        err_cnt = 0;
        step(1'b1, 2'd0, 16'h00e0, 1'b0);
        step(1'b1, 2'd1, 16'h00e1, 1'b0);
        step(1'b1, 2'd1, 16'hffff, 1'b0);
        step(1'b1, 2'd2, 16'h00e2, 1'b0);
        step(1'b1, 2'd3, 16'h00e3, 1'b0);
        chk("t6 seq_err pulses", 32'(err_cnt), 32'd1);
        chk("t6 kept first", 32'(m_data[1]), 32'h00e1);
        step(1'b0, 2'd0, 16'h0, 1'b1);
`endif

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, N - 1)), 16'($urandom),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysarr_result_collector.md
Name: sysarr_result_collector

Overview:
- Receive end of the systolic array's serialized result stream (data, valid, row index; no backpressure).
- Reassembles N serialized accumulator results into one parallel N-element result vector for downstream logic.
- Downstream side uses a valid/ready handshake.
- Two-bank ping-pong buffer: the next result stream is captured while the previous vector waits for downstream ready.

Parameters:
- DOUT_WIDTH, 16, width of each result element (2x array input width).
- N, 4, elements per frame (array dimension); N >= 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- s_data  input  DOUT_WIDTH  serialized result element
- s_valid  input  1  s_data/s_idx valid this cycle; no ready, source cannot stall
- s_idx  input  $clog2(N)  row index of s_data
- m_data  output  DOUT_WIDTH x N (unpacked [N])  reassembled result vector, element i = row i
- m_valid  output  1  m_data holds a complete frame
- m_ready  input  1  downstream accepts m_data
- ovf  output  1  one-cycle pulse: beat dropped because no bank was free
- busy  output  1  at least one bank is FILLING or FULL

Behaviour:
- Reset, clk and rst_n: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - m_valid=0, m_data all 0, ovf=0, busy=0.
  - Both banks EMPTY, wr_bank=0, rd_bank=0, masks cleared.
- Bank state per bank: EMPTY -> FILLING (first accepted beat) -> FULL (mask all ones) -> EMPTY (downstream handshake).
- Write side:
  - On s_valid, if bank[wr_bank] is not FULL: store s_data at element s_idx and set mask[s_idx].
  - If the mask is all ones after the write, the bank goes FULL and wr_bank toggles.
  - Beats are accepted in any index order; a frame completes on N distinct indices.
- Read side:
  - m_valid = (bank[rd_bank]==FULL).
  - m_data is driven from bank[rd_bank]; it must stay stable while m_valid && !m_ready.
  - On m_valid && m_ready: the bank goes EMPTY, its mask clears, rd_bank toggles.
- Latency: beat completing a frame at cycle T -> m_valid=1 at T+1 (registered), provided the other bank is not ahead in the queue.
- Ordering: frames leave in arrival order (strict ping-pong).
- Both banks FULL and s_valid=1: beat dropped, ovf=1 next cycle, no state change.
- Simultaneous release and write to the same bank (wr_bank==rd_bank, FULL, handshake this cycle, s_valid=1):
  - The beat is accepted into the freed bank.
  - Its mask becomes only that beat's bit; no ovf.
- Simultaneous write completion of one bank and handshake on the other: both take effect the same cycle.
- Duplicate index within a frame (mask bit already set): data overwritten, mask unchanged (default build).
- s_idx >= N (non-power-of-2 N): beat ignored.
- Reset mid-frame: partial frames and pending FULL banks are discarded; no m_valid until a new complete frame arrives.
- busy = any bank != EMPTY.

Optional Feature:
- Macro: SYSARR_COLLECT_ERR_CHECK_EN.
- Enabled:
  - Adds output seq_err (1 bit), a one-cycle pulse registered next cycle.
  - Pulses on a duplicate index within the current frame; that beat is ignored (no overwrite).
  - Pulses on s_idx >= N; beat ignored.
  - Pulses when the first beat of a frame has s_idx != 0; beat still accepted.
- Disabled: no seq_err port; duplicates overwrite; out-of-range ignored silently.

Decomposition:
- Package sysarr_pkg:
  - bank_state_e enum {BANK_EMPTY, BANK_FILLING, BANK_FULL}.
  - IDX_W helper: localparam/function $clog2(N).
  - Shared default widths (DIN_WIDTH=8, DOUT_WIDTH=16).
- Sub-module sysarr_result_bank:
  - One bank's storage, valid mask, state register.
  - write port (wr_en, idx, data), release input, full/empty/state outputs, parallel data out.
  - Instantiated twice.
- Top level: wr_bank/rd_bank pointers, drop/ovf logic, output mux.

Test Plan:
- Frame 0x0010,0x0020,0x0030,0x0040 (idx 0..3, back-to-back), m_ready=1 -> m_valid one cycle, one cycle after the idx-3 beat; m_data={0x10,0x20,0x30,0x40}.
- Out-of-order idx 2,0,3,1 -> m_data row-correct; completes on 4th beat.
- m_ready=0, send 3 frames -> frames 1,2 FULL, all 4 beats of frame 3 dropped, 4 ovf pulses; then m_ready=1 -> frames 1,2 delivered in order, m_data stable while stalled.
- Both banks FULL; m_ready=1 in the same cycle as a frame-3 idx 0 beat -> beat captured, no ovf; frame 3 completes and is delivered third.
- rst_n low after 2 beats of a frame, then a full frame A0..A3 -> only A frame delivered, m_valid never shows stale data.
- With SYSARR_COLLECT_ERR_CHECK_EN: idx 0,1,1(data 0xFFFF),2,3 -> one seq_err pulse, m_data[1] keeps the first value.
